// File: rtl/wb_select_reg.sv
// Writeback select stage: N-source select, load alignment, registered WB outputs,
// sticky error flags and a one-entry bypass of the last committed register write.
module wb_select_reg #(
    parameter int DATA_W  = 32,
    parameter int NSRC    = 4,
    parameter int SEL_W   = 2,
    parameter int MEM_IDX = 1,
    parameter int RA_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic [2:0]             load_type,
    input  logic [1:0]             addr_lo,
    input  logic [RA_W-1:0]        rd_addr,
    input  logic                   reg_write,
    output logic [DATA_W-1:0]      wb_data,
    output logic [RA_W-1:0]        wb_addr,
    output logic                   wb_we,
    output logic [DATA_W-1:0]      byp_data,
    output logic [RA_W-1:0]        byp_addr,
    output logic                   byp_valid,
    output logic                   err_sel,
    output logic                   err_align
);

    localparam logic [2:0] LT_BYTE_S = 3'd1;
    localparam logic [2:0] LT_BYTE_U = 3'd2;
    localparam logic [2:0] LT_HALF_S = 3'd3;
    localparam logic [2:0] LT_HALF_U = 3'd4;

    logic              legal_sel;
    logic              is_mem;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] aligned;
    logic              misalign;
    logic [DATA_W-1:0] next_data;
    logic              commit;

    always_comb begin
        legal_sel = (int'(sel) < NSRC);
        is_mem    = (int'(sel) == MEM_IDX);
        raw       = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) raw = src_data[i*DATA_W +: DATA_W];
        end
    end

    // Sub-word loads only exist on a 32-bit datapath; other widths are word-only.
    generate
        if (DATA_W == 32) begin : g_align32
            logic [7:0]  byte_k;
            logic [15:0] half_k;
            always_comb begin
                byte_k   = raw[8*addr_lo +: 8];
                half_k   = addr_lo[1] ? raw[31:16] : raw[15:0];
                aligned  = raw;
                misalign = 1'b0;
                if (is_mem) begin
                    case (load_type)
                        LT_BYTE_S: aligned = {{24{byte_k[7]}}, byte_k};
                        LT_BYTE_U: aligned = {24'd0, byte_k};
                        LT_HALF_S: begin
                            if (addr_lo[0]) misalign = 1'b1;
                            else aligned = {{16{half_k[15]}}, half_k};
                        end
                        LT_HALF_U: begin
                            if (addr_lo[0]) misalign = 1'b1;
                            else aligned = {16'd0, half_k};
                        end
                        default: misalign = (addr_lo != 2'b00);
                    endcase
                end
            end
        end else begin : g_align_word
            always_comb begin
                aligned  = raw;
                misalign = is_mem && (addr_lo != 2'b00);
            end
        end
    endgenerate

    always_comb begin
        next_data = legal_sel ? aligned : '0;
        commit    = in_valid & reg_write & (rd_addr != '0) & legal_sel & ~misalign;
    end

    // Flush beats stall; a stalled entry never re-asserts its write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data   <= '0;
            wb_addr   <= '0;
            wb_we     <= 1'b0;
            err_sel   <= 1'b0;
            err_align <= 1'b0;
        end else if (flush) begin
            wb_data <= '0;
            wb_addr <= '0;
            wb_we   <= 1'b0;
        end else if (stall) begin
            wb_we <= 1'b0;
        end else begin
            wb_data <= next_data;
            wb_addr <= rd_addr;
            wb_we   <= commit;
            if (in_valid && !legal_sel) err_sel <= 1'b1;
            if (in_valid && misalign)   err_align <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_data  <= '0;
            byp_addr  <= '0;
            byp_valid <= 1'b0;
        end else if (wb_we) begin
            byp_data  <= wb_data;
            byp_addr  <= wb_addr;
            byp_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_select_reg.sv
// Bench for wb_select_reg (NSRC=3 so that sel=3 is an illegal source):
// directed cases plus randomized traffic against a behavioural model.
module tb_wb_select_reg;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0, flush = 1'b0, in_valid = 1'b0, reg_write = 1'b0;
    logic [NS*DW-1:0] src_data = '0;
    logic [1:0]      sel = '0;
    logic [2:0]      load_type = '0;
    logic [1:0]      addr_lo = '0;
    logic [RW-1:0]   rd_addr = '0;
    logic [DW-1:0]   wb_data, byp_data;
    logic [RW-1:0]   wb_addr, byp_addr;
    logic            wb_we, byp_valid, err_sel, err_align;

    wb_select_reg #(.DATA_W(DW), .NSRC(NS), .SEL_W(2), .MEM_IDX(1), .RA_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .src_data(src_data), .sel(sel), .load_type(load_type), .addr_lo(addr_lo),
        .rd_addr(rd_addr), .reg_write(reg_write), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_we(wb_we), .byp_data(byp_data), .byp_addr(byp_addr), .byp_valid(byp_valid),
        .err_sel(err_sel), .err_align(err_align)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [DW-1:0] m_data, m_bd;
    logic [RW-1:0] m_addr, m_ba;
    logic          m_we, m_bv, m_es, m_ea;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_addr = '0; m_we = 0; m_bd = '0; m_ba = '0; m_bv = 0; m_es = 0; m_ea = 0;
    endtask

    // Expected load result and legality from the architectural rules.
    task automatic expect_result(output logic [31:0] d, output logic ok);
        logic [31:0] w;
        longint unsigned v;
        ok = 1;
        if (sel >= NS) begin
            d = 0; ok = 0; return;
        end
        w = src_data[sel*DW +: DW];
        d = w;
        if (sel != 1) return;
        case (load_type)
            3'd1, 3'd2: begin
                v = (longint'(w) >> (8 * addr_lo)) % 256;
                if (load_type == 3'd1 && v >= 128) v = v + 64'hFFFF_FF00;
                d = v[31:0];
            end
            3'd3, 3'd4: begin
                if (addr_lo % 2 == 1) ok = 0;
                else begin
                    v = (longint'(w) >> (8 * addr_lo)) % 65536;
                    if (load_type == 3'd3 && v >= 32768) v = v + 64'hFFFF_0000;
                    d = v[31:0];
                end
            end
            default: if (addr_lo != 0) ok = 0;
        endcase
    endtask

    task automatic model_edge();
        logic [31:0] d;
        logic ok;
        if (m_we) begin
            m_bd = m_data; m_ba = m_addr; m_bv = 1;
        end
        if (flush) begin
            m_data = 0; m_addr = 0; m_we = 0;
        end else if (stall) begin
            m_we = 0;
        end else begin
            expect_result(d, ok);
            m_data = d;
            m_addr = rd_addr;
            m_we = in_valid && reg_write && rd_addr != 0 && ok;
            if (in_valid && sel >= NS) m_es = 1;
            if (in_valid && sel < NS && !ok) m_ea = 1;
        end
    endtask

    task automatic check_all();
        check("wb_data", wb_data, m_data);
        check("wb_addr", 32'(wb_addr), 32'(m_addr));
        check("wb_we", 32'(wb_we), 32'(m_we));
        check("byp_data", byp_data, m_bd);
        check("byp_addr", 32'(byp_addr), 32'(m_ba));
        check("byp_valid", 32'(byp_valid), 32'(m_bv));
        check("err_sel", 32'(err_sel), 32'(m_es));
        check("err_align", 32'(err_align), 32'(m_ea));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] s, input logic [2:0] lt,
                         input logic [1:0] al, input logic [RW-1:0] rd, input logic st, input logic fl);
        in_valid = v; reg_write = rw; sel = s; load_type = lt; addr_lo = al;
        rd_addr = rd; stall = st; flush = fl;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1;
    endtask

    logic [31:0] held;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // basic capture then bypass
        src_data[0 +: 32] = 32'h0000_1234;
        drive(1, 1, 0, 0, 0, 5, 0, 0);
        step();
        check("t1_data", wb_data, 32'h0000_1234);
        check("t1_we", 32'(wb_we), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("t1_byp", byp_data, 32'h0000_1234);
        check("t1_bypa", 32'(byp_addr), 5);

        // load alignment
        src_data[32 +: 32] = 32'h80F1_7F82;
        drive(1, 1, 1, 1, 0, 6, 0, 0); step(); check("lb_s", wb_data, 32'hFFFF_FF82);
        drive(1, 1, 1, 2, 2, 6, 0, 0); step(); check("lb_u", wb_data, 32'h0000_00F1);
        drive(1, 1, 1, 3, 2, 6, 0, 0); step(); check("lh_s", wb_data, 32'hFFFF_80F1);
        drive(1, 1, 1, 4, 0, 6, 0, 0); step(); check("lh_u", wb_data, 32'h0000_7F82);

        // misaligned half load: sticky error until reset
        drive(1, 1, 1, 3, 1, 7, 0, 0); step();
        check("mis_we", 32'(wb_we), 0);
        check("mis_data", wb_data, 32'h80F1_7F82);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mis_sticky", 32'(err_align), 1);
        end
        @(negedge clk);
        do_reset();
        check("mis_cleared", 32'(err_align), 0);

        // stall: single write pulse, data held
        src_data[64 +: 32] = 32'hCAFE_0003;
        drive(1, 1, 2, 0, 0, 3, 0, 0); step();
        check("st_we0", 32'(wb_we), 1);
        held = wb_data;
        drive(1, 1, 0, 0, 0, 8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_we", 32'(wb_we), 0);
            check("st_hold", wb_data, held);
        end

        // flush with stall wins; bypass keeps last committed write
        drive(1, 1, 2, 0, 0, 4, 0, 0); step();
        drive(1, 1, 0, 0, 0, 9, 1, 1); step();
        check("fl_we", 32'(wb_we), 0);
        check("fl_addr", 32'(wb_addr), 0);
        check("fl_byp", 32'(byp_addr), 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        check("fl_byp2", 32'(byp_addr), 4);

        // illegal select and rd=0
        drive(0, 1, 3, 0, 0, 10, 0, 0); step();
        check("sel_nv", 32'(err_sel), 0);
        drive(1, 1, 3, 0, 0, 10, 0, 0); step();
        check("sel_we", 32'(wb_we), 0);
        check("sel_data", wb_data, 0);
        check("sel_err", 32'(err_sel), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0); step();
        check("rd0_we", 32'(wb_we), 0);
        step();
        check("rd0_byp", 32'(byp_addr), 4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
